// File: rtl/alu_selftest_engine.sv
`timescale 1ns/1ps
// Built-in self-test driver/checker for the 64-bit LEGv8 ALU: LFSR-generated operands,
// combinational golden model, error count and first-failure capture.
module alu_selftest_engine #(
    parameter int          NUM_VECTORS = 1000,
    parameter logic [63:0] SEED        = 64'h0000_0000_0000_0001,
    parameter int          SETTLE      = 1,
    parameter int          CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [63:0]      alu_F,
    output logic [63:0]      alu_A,
    output logic [63:0]      alu_B,
    output logic [4:0]       alu_FS,
    output logic             alu_C0,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] first_fail_index,
    output logic [4:0]       first_fail_FS,
    output logic [63:0]      first_fail_A,
    output logic [63:0]      first_fail_B,
    output logic             first_fail_C0
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN_A,
        S_GEN_B,
        S_GEN_CTRL,
        S_DRIVE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [63:0]      lfsr;
    logic [63:0]      lfsr_next;
    logic [CNT_W-1:0] vec_idx;
    logic [SW-1:0]    settle_cnt;
    logic [63:0]      a2;
    logic [63:0]      b2;
    logic [63:0]      expected;
    logic             mismatch;
    logic             last_vec;
    logic             settle_end;

    assign lfsr_next  = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
    assign last_vec   = (vec_idx == CNT_W'(NUM_VECTORS - 1));
    assign settle_end = (settle_cnt == SW'(SETTLE - 1));

    // Golden model works from the registered operands, so it sees exactly what the ALU sees.
    always_comb begin
        a2       = alu_FS[1] ? ~alu_A : alu_A;
        b2       = alu_FS[0] ? ~alu_B : alu_B;
        expected = '0;
        case (alu_FS[4:2])
            3'b000:  expected = a2 & b2;
            3'b001:  expected = a2 | b2;
            3'b010:  expected = a2 + b2 + {63'd0, alu_C0};
            3'b011:  expected = a2 ^ b2;
            3'b100:  expected = alu_A << alu_B[5:0];
            3'b101:  expected = alu_A >> alu_B[5:0];
            default: expected = '0;
        endcase
    end

    assign mismatch = (alu_F != expected);

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_next = S_GEN_A;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_next = S_GEN_A;
            end
            S_GEN_A:    state_next = S_GEN_B;
            S_GEN_B:    state_next = S_GEN_CTRL;
            S_GEN_CTRL: state_next = S_DRIVE;
            S_DRIVE:    if (settle_end) state_next = S_CHECK;
            S_CHECK:    state_next = last_vec ? S_DONE : S_GEN_A;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: reset clears every register, operands and results included, so a
        // mid-run reset leaves no partial result visible.
        if (reset) begin
            state            <= S_IDLE;
            lfsr             <= '0;
            vec_idx          <= '0;
            settle_cnt       <= '0;
            alu_A            <= '0;
            alu_B            <= '0;
            alu_FS           <= '0;
            alu_C0           <= 1'b0;
            pass             <= 1'b0;
            error_count      <= '0;
            first_fail_index <= '0;
            first_fail_FS    <= '0;
            first_fail_A     <= '0;
            first_fail_B     <= '0;
            first_fail_C0    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        lfsr             <= SEED;
                        vec_idx          <= '0;
                        pass             <= 1'b0;
                        error_count      <= '0;
                        first_fail_index <= '0;
                        first_fail_FS    <= '0;
                        first_fail_A     <= '0;
                        first_fail_B     <= '0;
                        first_fail_C0    <= 1'b0;
                    end
                end
                S_GEN_A: begin
                    lfsr  <= lfsr_next;
                    alu_A <= lfsr_next;
                end
                S_GEN_B: begin
                    lfsr  <= lfsr_next;
                    alu_B <= lfsr_next;
                end
                S_GEN_CTRL: begin
                    lfsr       <= lfsr_next;
                    alu_FS     <= lfsr_next[4:0];
                    alu_C0     <= lfsr_next[5];
                    settle_cnt <= '0;
                end
                S_DRIVE: settle_cnt <= settle_cnt + 1'b1;
                S_CHECK: begin
                    if (mismatch && error_count == '0) begin
                        first_fail_index <= vec_idx;
                        first_fail_FS    <= alu_FS;
                        first_fail_A     <= alu_A;
                        first_fail_B     <= alu_B;
                        first_fail_C0    <= alu_C0;
                    end
                    if (mismatch && error_count != '1) error_count <= error_count + 1'b1;
                    // pass is settled on the final check so it is valid as done rises.
                    if (last_vec) pass <= !mismatch && (error_count == '0);
                    else          vec_idx <= vec_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
